// File: rtl/data_sram_bridge_pkg.sv
// Shared definitions for the data-side SRAM bridge.
//   - state_t   : bridge FSM states (2-bit encoding)
//   - SZ_*      : core/bus access size codes
//   - KSEG_MASK : mask that folds kseg0/kseg1 onto physical memory
package data_bridge_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // kseg0 (0x8000_0000) and kseg1 (0xA000_0000) both alias physical 0.
  localparam logic [31:0] KSEG_MASK = 32'h1FFF_FFFF;

endpackage

// File: rtl/data_sram_bridge_if.sv
// SRAM-like split-handshake data bus (req/addr_ok, then data_ok).
//   master : request side (the bridge) drives req/wr/size/addr/wdata
//   slave  : memory side drives addr_ok/rdata/data_ok
interface data_sram_bridge_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic [31:0] data_rdata;
  logic        data_data_ok;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_rdata, data_data_ok
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_addr_ok, data_rdata, data_data_ok
  );
endinterface

// File: rtl/data_sram_bridge_kseg.sv
// Virtual-to-physical address map for kseg0/kseg1 (purely combinational).
//   i_vaddr : 32-bit virtual byte address
//   o_paddr : 32-bit physical byte address
// When KSEG_MAP=1 and the address lies in 0x8000_0000-0xBFFF_FFFF the top
// three bits are cleared; every other address passes through unchanged.
// Shared with the instruction-side bridge.
module kseg_addr_map
  import data_bridge_pkg::*;
#(
  parameter bit KSEG_MAP = 1'b1
) (
  input  logic [31:0] i_vaddr,
  output logic [31:0] o_paddr
);

  logic w_map;

  assign w_map = KSEG_MAP && (i_vaddr[31:30] == 2'b10);

  // Bits set in KSEG_MASK always survive; the others survive only when
  // the address is not being mapped.
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_bit
      assign o_paddr[gi] = i_vaddr[gi] & (KSEG_MASK[gi] | ~w_map);
    end
  endgenerate

endmodule

// File: rtl/data_sram_bridge.sv
// Memory-stage data port to SRAM-like bus bridge.
// Latches one M-stage load/store, issues a single bus transaction (or flags
// a misaligned access without touching the bus), stalls the pipeline until
// it completes, then holds the result until the pipeline advances.
// Ports:
//   clk, rst        : clock (rising edge), asynchronous active-low reset
//   cpu_en/cpu_wen  : M-stage memory access / store
//   cpu_size        : 0 byte, 1 half, 2 word (3 treated as word)
//   cpu_addr        : virtual byte address
//   cpu_wdata       : lane-aligned store data
//   pipe_stall      : stall from every other source in the pipeline
//   cpu_rdata       : load data, held until the pipeline advances
//   cpu_stall       : stall request from this block (combinational)
//   cpu_addr_err    : misaligned access, valid in DONE
//   bus             : master side of the data bus
module data_sram_bridge
  import data_bridge_pkg::*;
#(
  parameter bit          KSEG_MAP     = 1'b1,
  parameter logic [31:0] RDATA_ON_ERR = 32'h0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cpu_en,
  input  logic                      cpu_wen,
  input  logic [1:0]                cpu_size,
  input  logic [31:0]               cpu_addr,
  input  logic [31:0]               cpu_wdata,
  input  logic                      pipe_stall,
  output logic [31:0]               cpu_rdata,
  output logic                      cpu_stall,
  output logic                      cpu_addr_err,
  data_sram_bridge_if.master        bus
);

  state_t      r_state;
  state_t      w_state_next;

  logic        r_req;
  logic        r_wen;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_addr_err;

  logic [31:0] w_paddr;
  logic [1:0]  w_size_norm;
  logic        w_misaligned;

  kseg_addr_map #(
    .KSEG_MAP (KSEG_MAP)
  ) u_kseg (
    .i_vaddr (cpu_addr),
    .o_paddr (w_paddr)
  );

  // Size code 3 is folded onto word so the bus only ever sees 0/1/2.
  assign w_size_norm = (cpu_size == SZ_BYTE || cpu_size == SZ_HALF) ? cpu_size : SZ_WORD;

  always_comb begin
    w_misaligned = 1'b0;
    case (w_size_norm)
      SZ_HALF: w_misaligned = cpu_addr[0];
      SZ_WORD: w_misaligned = |cpu_addr[1:0];
      default: w_misaligned = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (cpu_en) begin
          w_state_next = w_misaligned ? S_DONE : S_ADDR;
        end
      end
      S_ADDR: begin
        if (bus.data_addr_ok) begin
          w_state_next = S_DATA;
        end
      end
      S_DATA: begin
        // A flush (cpu_en dropping) does not abort: the bus transaction
        // is already accepted and must be drained.
        if (bus.data_data_ok) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        // cpu_en may still be high for the same instruction while the rest
        // of the pipeline is stalled; only leaving DONE re-arms the bridge.
        if (!pipe_stall) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // ------------------------------------------------------ request / result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_req      <= 1'b0;
      r_wen      <= 1'b0;
      r_size     <= 2'd0;
      r_addr     <= 32'h0;
      r_wdata    <= 32'h0;
      r_rdata    <= 32'h0;
      r_addr_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cpu_en) begin
            r_wen   <= cpu_wen;
            r_size  <= w_size_norm;
            r_addr  <= w_paddr;
            r_wdata <= cpu_wdata;
            if (w_misaligned) begin
              r_addr_err <= 1'b1;
              r_rdata    <= RDATA_ON_ERR;
            end else begin
              r_req <= 1'b1;
            end
          end
        end
        S_ADDR: begin
          // Dropping req on acceptance means a lingering addr_ok in DATA
          // can never be taken as a second request.
          if (bus.data_addr_ok) begin
            r_req <= 1'b0;
          end
        end
        S_DATA: begin
          if (bus.data_data_ok && !r_wen) begin
            r_rdata <= bus.data_rdata;
          end
        end
        S_DONE: begin
          if (!pipe_stall) begin
            r_addr_err <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.data_req   = r_req;
  assign bus.data_wr    = r_wen;
  assign bus.data_size  = r_size;
  assign bus.data_addr  = r_addr;
  assign bus.data_wdata = r_wdata;

  assign cpu_rdata    = r_rdata;
  assign cpu_addr_err = r_addr_err;
  assign cpu_stall    = cpu_en & (r_state != S_DONE);

endmodule

// File: tb/tb_data_sram_bridge.sv
module tb_data_sram_bridge;

  localparam logic [31:0] RDATA_ON_ERR = 32'h0;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_exp_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } res_exp_t;

  logic        clk;
  logic        rst;
  logic        cpu_en;
  logic        cpu_wen;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        pipe_stall;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        cpu_addr_err;

  data_sram_bridge_if bus_if ();

  data_sram_bridge #(
    .KSEG_MAP     (1'b1),
    .RDATA_ON_ERR (RDATA_ON_ERR)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_en       (cpu_en),
    .cpu_wen      (cpu_wen),
    .cpu_size     (cpu_size),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .pipe_stall   (pipe_stall),
    .cpu_rdata    (cpu_rdata),
    .cpu_stall    (cpu_stall),
    .cpu_addr_err (cpu_addr_err),
    .bus          (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;
  int req_cycles = 0;
  int txn_id = 0;

  bus_exp_t bus_q[$];
  res_exp_t res_q[$];
  logic [31:0] model_rdata = 32'h0;

  // slave behaviour knobs, set by the stimulus before each access
  int          slv_addr_wait = 1;
  int          slv_data_wait = 1;
  logic [31:0] slv_rdata = 32'h0;
  int          slv_phase = 0;
  int          slv_cnt = 0;
  bus_exp_t    slv_e;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] map_addr(input logic [31:0] a);
    if (a[31:30] == 2'b10) return {3'b000, a[28:0]};
    return a;
  endfunction

  // Count cycles in which a request is on the bus.
  initial begin
    forever begin
      @(negedge clk);
      if (bus_if.data_req === 1'b1) req_cycles++;
    end
  end

  // Memory-side responder: checks request fields every cycle req is high
  // and answers after the configured number of cycles.
  initial begin
    bus_if.data_addr_ok = 1'b0;
    bus_if.data_data_ok = 1'b0;
    bus_if.data_rdata   = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      bus_if.data_addr_ok = 1'b0;
      bus_if.data_data_ok = 1'b0;
      bus_if.data_rdata   = $urandom;
      if (!rst) begin
        slv_phase = 0;
        slv_cnt   = 0;
      end else if (slv_phase == 0) begin
        if (bus_if.data_req === 1'b1) begin
          slv_cnt++;
          if (bus_q.size() == 0) begin
            check_value("unexpected_req", 32'd1, 32'd0);
          end else begin
            slv_e = bus_q[0];
            check_value("bus_wr",    {31'd0, bus_if.data_wr},   {31'd0, slv_e.wr});
            check_value("bus_size",  {30'd0, bus_if.data_size}, {30'd0, slv_e.size});
            check_value("bus_addr",  bus_if.data_addr,          slv_e.addr);
            check_value("bus_wdata", bus_if.data_wdata,         slv_e.wdata);
            if (slv_cnt >= slv_addr_wait) begin
              bus_if.data_addr_ok = 1'b1;
              void'(bus_q.pop_front());
              slv_phase = 1;
              slv_cnt   = 0;
            end
          end
        end
      end else begin
        check_value("req_in_data", {31'd0, bus_if.data_req}, 32'd0);
        slv_cnt++;
        if (slv_cnt >= slv_data_wait) begin
          bus_if.data_data_ok = 1'b1;
          bus_if.data_rdata   = slv_rdata;
          slv_phase = 0;
          slv_cnt   = 0;
        end
      end
    end
  end

  // Called at posedge+1 with the bridge in IDLE; returns at posedge+1 with
  // the bridge back in IDLE and cpu_en still asserted.
  task automatic do_access(input string name, input logic wen, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] brdata, input int aw, input int dw,
                           input int hold);
    bit       mis;
    int       exp_stall;
    int       stalls;
    int       req0;
    res_exp_t r;
    bus_exp_t b;
    mis = (size == 2'd1 && addr[0]) || (size >= 2'd2 && addr[1:0] != 2'b00);
    if (mis) begin
      model_rdata = RDATA_ON_ERR;
      r.rdata = RDATA_ON_ERR;
      r.err = 1'b1;
      exp_stall = 1;
    end else begin
      b.wr = wen;
      b.size = size;
      b.addr = map_addr(addr);
      b.wdata = wdata;
      bus_q.push_back(b);
      if (!wen) model_rdata = brdata;
      r.rdata = model_rdata;
      r.err = 1'b0;
      exp_stall = 1 + aw + dw;
    end
    res_q.push_back(r);
    slv_addr_wait = aw;
    slv_data_wait = dw;
    slv_rdata = brdata;
    req0 = req_cycles;
    cpu_en = 1'b1;
    cpu_wen = wen;
    cpu_size = size;
    cpu_addr = addr;
    cpu_wdata = wdata;
    pipe_stall = (hold > 0);
    stalls = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!cpu_stall) break;
      stalls++;
    end
    if (stalls >= 100) check_value("stall_timeout", 32'd1, 32'd0);
    r = res_q.pop_front();
    check_value("stall_cycles", stalls, exp_stall);
    check_value("cpu_rdata", cpu_rdata, r.rdata);
    check_value("cpu_addr_err", {31'd0, cpu_addr_err}, {31'd0, r.err});
    check_value("req_cycles", req_cycles - req0, mis ? 0 : aw);
    txn_id++;
    $display("txn %0d %s: wen=%0b size=%0d addr=%h stalls=%0d rdata=%h err=%0b",
             txn_id, name, wen, size, addr, stalls, cpu_rdata, cpu_addr_err);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_value("hold_stall", {31'd0, cpu_stall}, 32'd0);
      check_value("hold_rdata", cpu_rdata, r.rdata);
      check_value("hold_no_req", req_cycles - req0, mis ? 0 : aw);
    end
    pipe_stall = 1'b0;
    @(posedge clk);
    #1;
    check_value("back_to_idle", {31'd0, cpu_stall}, 32'd1);
    check_value("err_cleared", {31'd0, cpu_addr_err}, 32'd0);
  endtask

  task automatic go_idle(input int n);
    cpu_en = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_exp_t b;
    rst = 1'b0;
    cpu_en = 1'b0;
    cpu_wen = 1'b0;
    cpu_size = 2'd0;
    cpu_addr = 32'h0;
    cpu_wdata = 32'h0;
    pipe_stall = 1'b0;
    #3;
    check_value("rst_rdata", cpu_rdata, 32'h0);
    check_value("rst_err", {31'd0, cpu_addr_err}, 32'd0);
    check_value("rst_req", {31'd0, bus_if.data_req}, 32'd0);
    check_value("rst_wr", {31'd0, bus_if.data_wr}, 32'd0);
    check_value("rst_size", {30'd0, bus_if.data_size}, 32'd0);
    check_value("rst_addr", bus_if.data_addr, 32'h0);
    check_value("rst_wdata", bus_if.data_wdata, 32'h0);
    check_value("rst_stall_lo", {31'd0, cpu_stall}, 32'd0);
    cpu_en = 1'b1;
    #1;
    check_value("rst_stall_hi", {31'd0, cpu_stall}, 32'd1);
    cpu_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    do_access("aligned_load", 1'b0, 2'd2, 32'hBFC0_0010, $urandom, 32'h1234_5678, 1, 1, 0);
    go_idle(2);
    do_access("store_slow_ack", 1'b1, 2'd0, 32'h8000_0003, 32'h0000_00AA, 32'hDEAD_0000, 4, 1, 0);
    go_idle(1);
    do_access("misaligned_word", 1'b0, 2'd2, 32'h8000_0002, $urandom, 32'h5555_5555, 1, 1, 0);
    go_idle(1);
    do_access("misaligned_half", 1'b1, 2'd1, 32'hA000_0001, 32'h0000_BEEF, 32'h0, 1, 1, 0);
    go_idle(1);
    do_access("hold_load", 1'b0, 2'd2, 32'h8000_0040, $urandom, 32'hCAFE_F00D, 1, 1, 3);
    go_idle(1);
    do_access("kseg2_load", 1'b0, 2'd1, 32'hC000_0042, $urandom, 32'h0BAD_BEEF, 2, 3, 0);

    // reset while the bus is in its data phase
    b.wr = 1'b0;
    b.size = 2'd2;
    b.addr = map_addr(32'h8000_0100);
    b.wdata = 32'h0;
    bus_q.push_back(b);
    slv_addr_wait = 1;
    slv_data_wait = 6;
    slv_rdata = 32'h7777_7777;
    cpu_en = 1'b1;
    cpu_wen = 1'b0;
    cpu_size = 2'd2;
    cpu_addr = 32'h8000_0100;
    cpu_wdata = 32'h0;
    repeat (3) @(negedge clk);
    check_value("pre_rst_req", {31'd0, bus_if.data_req}, 32'd0);
    check_value("pre_rst_stall", {31'd0, cpu_stall}, 32'd1);
    rst = 1'b0;
    #1;
    check_value("mid_rst_req", {31'd0, bus_if.data_req}, 32'd0);
    check_value("mid_rst_rdata", cpu_rdata, 32'h0);
    check_value("mid_rst_addr", bus_if.data_addr, 32'h0);
    model_rdata = 32'h0;
    txn_id++;
    $display("txn %0d reset_in_data: rdata=%h req=%0b", txn_id, cpu_rdata, bus_if.data_req);
    cpu_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    do_access("load_after_reset", 1'b0, 2'd2, 32'h0000_2000, $urandom, 32'h3141_5926, 2, 2, 0);
    do_access("b2b_load_a", 1'b0, 2'd2, 32'h8000_1000, $urandom, 32'hA5A5_0001, 1, 1, 0);
    do_access("b2b_load_b", 1'b0, 2'd0, 32'h8000_1007, $urandom, 32'h0000_0042, 1, 2, 0);
    go_idle(1);
    do_access("word_store", 1'b1, 2'd2, 32'h0000_1004, 32'hFEED_FACE, 32'h0, 2, 3, 0);
    go_idle(3);
    check_value("final_stall", {31'd0, cpu_stall}, 32'd0);
    check_value("final_req", {31'd0, bus_if.data_req}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/data_sram_bridge.md
Name: data_sram_bridge

Overview:
- Sits between the pipelined core's memory-stage data port and a SRAM-like split-handshake data bus (req/addr_ok then data_ok).
- Latches each M-stage load/store, drives one bus transaction and maps kseg0/kseg1 virtual addresses to physical.
- Holds the pipeline stalled until the transaction completes, then holds the read data stable until the pipeline advances.

Parameters:
- KSEG_MAP, 1, when 1 map addresses 0x8000_0000-0xBFFF_FFFF to physical by clearing addr[31:29]; when 0 pass addresses through.
- RDATA_ON_ERR, 32'h0, value returned on cpu_rdata after a misaligned access.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- cpu_en  in  1  M-stage instruction is a load or store.
- cpu_wen  in  1  1 = store, 0 = load.
- cpu_size  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
- cpu_addr  in  32  virtual byte address (aluoutM).
- cpu_wdata  in  32  store data (writedataM), already lane-aligned by the core.
- pipe_stall  in  1  global pipeline stall from all other sources, excluding this block's own.
- cpu_rdata  out  32  load data.
- cpu_stall  out  1  stall request to the hazard unit.
- cpu_addr_err  out  1  misaligned access; valid while state is DONE.
- data_req  out  1  bus request.
- data_wr  out  1  bus write.
- data_size  out  2  bus size.
- data_addr  out  32  physical address.
- data_wdata  out  32  bus write data.
- data_addr_ok  in  1  request accepted.
- data_rdata  in  32  bus read data.
- data_data_ok  in  1  transaction complete.

Behaviour:
- Reset (rst=0, asynchronous):
  - State is IDLE and all request latches are 0.
  - cpu_rdata=0, cpu_addr_err=0, data_req=0, data_wr=0, data_size=0, data_addr=0, data_wdata=0.
  - cpu_stall = cpu_en, because the combinational rule below holds in IDLE.
- States are IDLE, ADDR, DATA and DONE. Encoding is 2 bits and lives in the package.
- IDLE:
  - On cpu_en=1, latch wen, size, mapped address and wdata.
  - If the access is misaligned (half with addr[0]=1, or word with addr[1:0]!=0), go to DONE with cpu_addr_err=1 and cpu_rdata=RDATA_ON_ERR. No bus request is made.
  - Otherwise go to ADDR.
- ADDR:
  - data_req=1; data_wr, data_size, data_addr and data_wdata come from the latches and stay stable while req is high.
  - On data_addr_ok=1, go to DATA. data_data_ok is ignored in this state.
- DATA:
  - data_req=0.
  - On data_data_ok=1, go to DONE. For a load, cpu_rdata <= data_rdata; for a store, cpu_rdata keeps its value.
- DONE:
  - Results are held.
  - When pipe_stall=0 at the clock edge, go to IDLE and clear cpu_addr_err.
  - When pipe_stall=1, stay in DONE. The access is not reissued even though cpu_en is still high.
- cpu_stall = cpu_en & (state != DONE), combinational. This is the only combinational output.
- Minimum latency for an aligned access with addr_ok and data_ok each one cycle after they become possible: cpu_en is seen at cycle 0, req in cycle 1, DATA in cycle 2, cpu_stall low in cycle 3. The core therefore sees 3 stall cycles.
- A misaligned access gives 1 stall cycle.
- data_addr_ok held high in consecutive cycles: only the first is consumed, because data_req is already 0 in DATA.
- Reset during ADDR or DATA abandons the transaction; the bus is reset on the same rst.
- cpu_en falling while in ADDR or DATA (pipeline flush) does not abort the bus transaction. The FSM completes to DONE, and with pipe_stall=0 it returns to IDLE on the next edge.
- Address mapping:
  - Applied only when KSEG_MAP=1 and addr[31:30]=2'b10.
  - Then phys = {3'b000, addr[28:0]}.
  - Otherwise phys = addr.

Decomposition:
- Package data_bridge_pkg holds:
  - state localparams S_IDLE, S_ADDR, S_DATA, S_DONE;
  - size codes SZ_BYTE, SZ_HALF, SZ_WORD;
  - the kseg mask constant.
- One combinational sub-module, kseg_addr_map (32-bit virtual in, physical out, KSEG_MAP parameter). It is reused by the instruction-side bridge.
- The misalignment check is inline.

Test Plan:
- Aligned load: cpu_en=1, wen=0, size=2, addr=0xBFC0_0010, addr_ok and data_ok each one cycle later with data_rdata=0x1234_5678. Expect data_addr=0x1FC0_0010, data_req high for exactly 1 cycle, 3 stall cycles, then cpu_rdata=0x1234_5678.
- Store with delayed addr_ok: wen=1, size=0, addr=0x8000_0003, wdata=0xAA, addr_ok after 4 cycles. Expect data_req held 4 cycles with data_addr=0x0000_0003, data_wr=1, data_size=0 and data_wdata=0xAA stable throughout; cpu_stall drops only after data_ok.
- Misaligned: size=2, addr=0x8000_0002. Expect no data_req, 1 stall cycle, cpu_addr_err=1, cpu_rdata=0.
- External stall hold: load completes with pipe_stall=1 for 3 cycles. Expect state DONE, cpu_stall=0, cpu_rdata stable and no second data_req. Release pipe_stall; expect IDLE on the next edge.
- Reset mid-transaction: assert rst=0 in DATA. Expect immediate IDLE, data_req=0, cpu_rdata=0. After release, a new load completes normally.
- Back-to-back: two consecutive loads with pipe_stall=0. Expect two separate req pulses and correct cpu_rdata for each.
